// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped I/O responder that sits beside the RAM on the
// CPU bus. It answers when mem_addr[IO_BIT] is set and holds a 5-bit LED
// register plus an 8N1 UART transmitter whose busy flag can be polled.
//
// Ports
//   clk        clock
//   resetn     synchronous reset, active-low
//   mem_addr   byte address from the processor
//   mem_wdata  write data (already lane-replicated)
//   mem_wmask  byte write enables, lane 0 is the only one used here
//   mem_rstrb  read strobe
//   mem_rdata  registered read data, one cycle after mem_rstrb
//   leds       LED register
//   txd        UART serial output, idle high
//
// Register map (offset = mem_addr[3:2])
//   0 LEDS   R/W  bits[4:0]
//   1 TXDATA W    starts a frame when idle, dropped while busy, reads 0
//   2 STATUS R    bit0 = busy
//   3 -           reads 0, writes ignored
//
// TX FSM
//   state   | meaning
//   S_IDLE  | line high, waiting for a TXDATA write
//   S_START | start bit (low) for DIV cycles
//   S_DATA  | 8 data bits, LSB first, DIV cycles each
//   S_STOP  | stop bit (high) for DIV cycles
module mmio_uart_tx #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int BAUD        = 115_200,
  parameter int IO_BIT      = 22
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic [4:0]  leds,
  output logic        txd
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [4:0]    leds_q, leds_d;
  logic [31:0]   rdata_q, rdata_d;

  logic       sel;
  logic [1:0] off;
  logic       wr_lane0;
  logic       busy;
  logic       baud_done;
  logic       unused_bus;

  assign sel       = mem_addr[IO_BIT];
  assign off       = mem_addr[3:2];
  assign wr_lane0  = sel & mem_wmask[0];
  assign busy      = (state_q != S_IDLE);
  assign baud_done = (cnt_q == LAST);

  assign unused_bus = ^{mem_addr, mem_wdata[31:8], mem_wmask[3:1]};

  // Bus side: LED write and registered read. The read mux uses the current
  // (pre-edge) register values, so a same-cycle write is not visible yet.
  always_comb begin
    leds_d  = leds_q;
    rdata_d = rdata_q;
    if (wr_lane0 && off == 2'd0) leds_d = mem_wdata[4:0];
    if (sel && mem_rstrb) begin
      case (off)
        2'd0:    rdata_d = {27'd0, leds_q};
        2'd2:    rdata_d = {31'd0, busy};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // TX next-state logic. The baud counter runs 0..DIV-1 in every non-idle
  // state and wraps on the bit boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (wr_lane0 && off == 2'd1) begin
          shift_d = mem_wdata[7:0];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      leds_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      leds_q  <= leds_d;
      rdata_q <= rdata_d;
    end
  end

  // txd decodes registered state only, so reset forces it high on the very
  // next cycle and nothing on the bus can reach it combinationally.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign leds      = leds_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] A_LEDS   = 32'h0040_0000;
  localparam logic [31:0] A_TXDATA = 32'h0040_0004;
  localparam logic [31:0] A_STATUS = 32'h0040_0008;
  localparam logic [31:0] A_OFF3   = 32'h0040_000C;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic [4:0]  leds;
  logic        txd;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  mmio_uart_tx #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD(100_000),
    .IO_BIT(22)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata),
    .leds(leds),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    tick();
    mem_wmask = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr  = a;
    mem_rstrb = 1'b1;
    tick();
    mem_rstrb = 1'b0;
    d = mem_rdata;
  endtask

  function automatic logic exp_txd(input logic [7:0] b, input int i);
    int k;
    k = i / 10;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Called in cycle 0 of a frame; returns in cycle 100. Optionally injects a
  // TXDATA write during cycle inj and checks a held STATUS read each cycle.
  task automatic frame(input logic [7:0] b, input int inj, input logic [7:0] inj_d,
                       input bit chk_st);
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("txd[%0d]", i), {31'd0, txd}, {31'd0, exp_txd(b, i)});
      if (chk_st && i > 0) chk($sformatf("busy[%0d]", i), mem_rdata, 32'h1);
      if (i == inj) begin
        mem_addr  = A_TXDATA;
        mem_wdata = {24'd0, inj_d};
        mem_wmask = 4'b0001;
      end
      tick();
      mem_wmask = 4'b0000;
    end
  endtask

  initial begin
    resetn    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wmask = 4'b0000;
    mem_rstrb = 1'b0;
    tick();
    tick();

    // 1. reset state
    chk("rst_txd", {31'd0, txd}, 32'h1);
    chk("rst_leds", {27'd0, leds}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    tick();
    bus_read(A_STATUS, rd);
    chk("idle_status", rd, 32'h0);

    // 2. 0x55 frame with STATUS polled every cycle
    bus_write(A_TXDATA, 32'h55, 4'b0001);
    mem_addr  = A_STATUS;
    mem_rstrb = 1'b1;
    frame(8'h55, -1, 8'h00, 1'b1);
    chk("f55_end_txd", {31'd0, txd}, 32'h1);
    chk("f55_busy99", mem_rdata, 32'h1);
    tick();
    chk("f55_status100", mem_rdata, 32'h0);
    mem_rstrb = 1'b0;

    // 3. write while busy is dropped; write at cycle 100 is accepted
    bus_write(A_TXDATA, 32'hA3, 4'b0001);
    frame(8'hA3, 40, 8'h11, 1'b0);
    chk("fA3_end_txd", {31'd0, txd}, 32'h1);
    bus_write(A_TXDATA, 32'h11, 4'b0001);
    frame(8'h11, -1, 8'h00, 1'b0);
    chk("f11_end_txd", {31'd0, txd}, 32'h1);

    // 4. LED register
    bus_write(A_LEDS, 32'h1F, 4'b0001);
    chk("leds_wr", {27'd0, leds}, 32'h1F);
    bus_read(A_LEDS, rd);
    chk("leds_rd", rd, 32'h1F);
    bus_write(32'h0000_0000, 32'h0A, 4'b0001);
    chk("leds_sel0", {27'd0, leds}, 32'h1F);
    bus_write(A_LEDS, 32'h0A, 4'b0010);
    chk("leds_lane1", {27'd0, leds}, 32'h1F);
    bus_read(32'h0000_0008, rd);
    chk("rd_sel0_hold", rd, 32'h1F);
    bus_read(A_OFF3, rd);
    chk("rd_off3", rd, 32'h0);
    bus_read(A_TXDATA, rd);
    chk("rd_txdata", rd, 32'h0);

    // 5. reset in the middle of a frame
    bus_write(A_TXDATA, 32'h00, 4'b0001);
    repeat (35) tick();
    chk("mid_txd35", {31'd0, txd}, 32'h0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_txd", {31'd0, txd}, 32'h1);
    chk("mrst_leds", {27'd0, leds}, 32'h0);
    chk("mrst_rdata", mem_rdata, 32'h0);
    bus_read(A_STATUS, rd);
    chk("mrst_status", rd, 32'h0);
    bus_write(A_TXDATA, 32'h3C, 4'b0001);
    frame(8'h3C, -1, 8'h00, 1'b0);
    chk("f3C_end_txd", {31'd0, txd}, 32'h1);
    bus_read(A_STATUS, rd);
    chk("f3C_status", rd, 32'h0);

    // 6. read and write in the same cycle return the pre-write value
    mem_addr  = A_LEDS;
    mem_wdata = 32'h05;
    mem_wmask = 4'b0001;
    mem_rstrb = 1'b1;
    tick();
    mem_wmask = 4'b0000;
    mem_rstrb = 1'b0;
    chk("rw_leds_pre", mem_rdata, 32'h0);
    chk("rw_leds_val", {27'd0, leds}, 32'h05);
    bus_read(A_LEDS, rd);
    chk("rw_leds_post", rd, 32'h05);
    bus_read(A_STATUS, rd);
    chk("rw_status_pre", rd, 32'h0);
    mem_addr  = A_TXDATA;
    mem_wdata = 32'h81;
    mem_wmask = 4'b0001;
    mem_rstrb = 1'b1;
    tick();
    mem_wmask = 4'b0000;
    mem_rstrb = 1'b0;
    chk("rw_tx_pre", mem_rdata, 32'h0);
    bus_read(A_STATUS, rd);
    chk("rw_status_post", rd, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
